// File: rtl/mul_div_hilo.sv
// mul_div_hilo: HI/LO register pair with a sequential signed multiplier and
// a restoring divider sharing one 2*WIDTH accumulator.
// Build option: define HILO_DIV_EN to include the divide datapath; without
// it a DIV request completes immediately and leaves HI/LO untouched.
//
// state | meaning
// IDLE  | waiting; MTHI/MTLO write here, MUL/DIV operands captured on Start
// ITER  | one shift-add (MUL) or restore step (DIV) per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO written at the exit edge
// DONE  | one-cycle completion pulse (DivZero also set for divide by zero)
module mul_div_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg_p;
  logic                 r_dz;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_cnt_tc;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_next_acc;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign w_a_mag  = A[WIDTH-1] ? ('0 - A) : A;
  assign w_b_mag  = B[WIDTH-1] ? ('0 - B) : B;
  assign w_cnt_tc = (r_cnt == '0);

  // Multiplier held in the low half, shifted out LSB first; the partial sum
  // keeps its carry by shifting into the top of the accumulator.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg_p ? ('0 - r_acc) : r_acc;

`ifdef HILO_DIV_EN
  logic                 r_is_div;
  logic                 r_neg_a;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;

  // Partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)),
  // so after the shift it still fits in WIDTH bits.
  assign w_b_zero    = (B == '0);
  assign w_div_shift = {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {1'b0, r_opnd};
  assign w_div_step  = w_div_diff[WIDTH] ? {w_div_shift, r_acc[WIDTH-2:0], 1'b0}
                                         : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_quot      = r_neg_p ? ('0 - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem       = r_neg_a ? ('0 - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
  assign w_next_acc  = r_is_div ? w_div_step : w_mul_step;
  assign w_res_hi    = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo    = r_is_div ? w_quot : w_prod[WIDTH-1:0];
`else
  assign w_next_acc  = w_mul_step;
  assign w_res_hi    = w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo    = w_prod[WIDTH-1:0];
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (Clear) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; Start is only looked at in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (Start && Op == 2'b00) begin
          w_next = ITER;
        end else if (Start && Op == 2'b01) begin
`ifdef HILO_DIV_EN
          w_next = w_b_zero ? DONE : ITER;
`else
          w_next = DONE;
`endif
        end
      end
      ITER:    if (w_cnt_tc) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and HI/LO update.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_neg_p <= 1'b0;
      r_dz    <= 1'b0;
`ifdef HILO_DIV_EN
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
`endif
    end else begin
      r_dz <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            case (Op)
              2'b00: begin
                r_opnd  <= w_a_mag;
                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                r_neg_p <= A[WIDTH-1] ^ B[WIDTH-1];
                r_cnt   <= CW'(WIDTH - 1);
`ifdef HILO_DIV_EN
                r_is_div <= 1'b0;
`endif
              end
`ifdef HILO_DIV_EN
              2'b01: begin
                if (w_b_zero) begin
                  r_dz <= 1'b1;
                end else begin
                  r_opnd   <= w_b_mag;
                  r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                  r_neg_p  <= A[WIDTH-1] ^ B[WIDTH-1];
                  r_neg_a  <= A[WIDTH-1];
                  r_is_div <= 1'b1;
                  r_cnt    <= CW'(WIDTH - 1);
                end
              end
`endif
              2'b10:   r_hi <= A;
              2'b11:   r_lo <= A;
              default: ;
            endcase
          end
        end
        ITER: begin
          r_acc <= w_next_acc;
          if (!w_cnt_tc) r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign Busy    = (r_state == ITER) || (r_state == FIX);
  assign Done    = (r_state == DONE);
  assign DivZero = r_dz;

endmodule

// File: tb/tb_mul_div_hilo.sv
// Bench for mul_div_hilo (WIDTH=32): vector table of MUL/DIV cases plus
// hand-built sequences for MTHI/MTLO, ignored starts, and Clear abort.
// Expected completions go into a queue when Start is driven; a monitor pops
// and compares them when Done appears.
module tb_mul_div_hilo;
  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Clear, Start;
  logic [1:0]   Op;
  logic [W-1:0] A, B, HI, LO;
  logic         Busy, Done, DivZero;

  mul_div_hilo #(.WIDTH(W)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Op(Op), .A(A), .B(B),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   viol = 0;
  bit   mon_en = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [W-1:0] m_hi, m_lo;

  always @(posedge Clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on Done plus per-cycle output invariants.
  always @(negedge Clock) begin
    if (mon_en) begin
      if (Busy === 1'b1 && Done === 1'b1) begin
        viol++;
        $display("FAIL busy_and_done at cycle %0d: both 1, required not both", cyc);
      end
      if (DivZero === 1'b1 && Done !== 1'b1) begin
        viol++;
        $display("FAIL divzero_without_done at cycle %0d: DivZero=1 Done=%b", cyc, Done);
      end
      if (Done === 1'b1) begin
        n_done++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: Done=1, required 0", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.due));
          chk("result_hi", 64'(HI), 64'(mon_e.hi));
          chk("result_lo", 64'(LO), 64'(mon_e.lo));
          chk("result_divzero", 64'(DivZero), 64'(mon_e.dz));
        end
      end
    end
  end

  // One operation: drive Start for one cycle, scramble A/B afterwards, and
  // for MUL/DIV wait (bounded) for the monitor to consume the expectation.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz, input int lat);
    logic [W-1:0] hi0, lo0;
    int busy_n, hold_bad, t;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    hi0 = HI; lo0 = LO;
    if (op[1] == 1'b0) sbq.push_back('{eh, el, edz, cyc + 1 + lat});
    @(negedge Clock);
    Start = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom_range(0, 3));
    if (op[1] == 1'b1) begin
      chk("mt_hi", 64'(HI), 64'(eh));
      chk("mt_lo", 64'(LO), 64'(el));
      chk("mt_busy", 64'(Busy), 64'd0);
      chk("mt_done", 64'(Done), 64'd0);
    end else begin
      busy_n = 0; hold_bad = 0; t = 0;
      while (sbq.size() != 0 && t < W + 10) begin
        if (Busy === 1'b1) begin
          busy_n++;
          if (HI !== hi0 || LO !== lo0) hold_bad++;
        end
        @(negedge Clock);
        t++;
      end
      if (sbq.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no Done within %0d cycles, required one", W + 10);
        sbq.delete();
      end
      chk("busy_cycles", 64'(busy_n), 64'((lat == 0) ? 0 : W + 1));
      chk("hilo_hold_while_busy", 64'(hold_bad), 64'd0);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vt[15];

  initial begin
    int t, n0;
    logic div_en;
`ifdef HILO_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    vt[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vt[1]  = '{2'b00, 32'd7,         32'd6,        32'h0,         32'd42};
    vt[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vt[3]  = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vt[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};
    vt[5]  = '{2'b00, 32'h1234_5678, 32'h0,        32'h0,         32'h0};
    vt[6]  = '{2'b00, 32'hFFFF_FFF9, 32'h8000_0000, 32'h3,         32'h8000_0000};
    vt[7]  = '{2'b01, 32'd17,        32'd5,        32'd2,         32'd3};
    vt[8]  = '{2'b01, 32'hFFFF_FFEF, 32'd5,        32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vt[9]  = '{2'b01, 32'd17,        32'hFFFF_FFFB, 32'd2,        32'hFFFF_FFFD};
    vt[10] = '{2'b01, 32'hFFFF_FFEF, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'd3};
    vt[11] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    vt[12] = '{2'b01, 32'h7FFF_FFFF, 32'd1,        32'h0,         32'h7FFF_FFFF};
    vt[13] = '{2'b01, 32'd3,         32'd7,        32'd3,         32'd0};
    vt[14] = '{2'b01, 32'h8000_0000, 32'd2,        32'h0,         32'hC000_0000};

    Clear = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    chk("reset_hi", 64'(HI), 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_divzero", 64'(DivZero), 64'd0);
    m_hi = '0; m_lo = '0;
    Clear = 1'b0;
    mon_en = 1'b1;

    // MTHI then MTLO, each visible right after its edge.
    do_op(2'b10, 32'd10, 32'd0, 32'h0000_000A, m_lo, 1'b0, 0);
    do_op(2'b11, 32'h55, 32'd0, m_hi, 32'h55, 1'b0, 0);

    // Divide by zero (or disabled divider): immediate Done, HI/LO unchanged.
    do_op(2'b01, 32'd7, 32'd0, m_hi, m_lo, div_en, 0);
    chk("divzero_lo_kept", 64'(LO), 64'h55);

    foreach (vt[i]) begin
      if (vt[i].op == 2'b01 && !div_en)
        do_op(vt[i].op, vt[i].a, vt[i].b, m_hi, m_lo, 1'b0, 0);
      else
        do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 1'b0, W + 1);
    end

    // Starts during Busy and during DONE must be ignored.
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; A = 32'hFFFF_FFFD; B = 32'd5;
    sbq.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, cyc + 1 + W + 1});
    @(negedge Clock);
    Start = 1'b0; A = 32'h1; B = 32'h1;
    repeat (4) @(negedge Clock);
    Start = 1'b1; Op = 2'b10; A = 32'hDEAD_BEEF; B = 32'h0;
    @(negedge Clock);
    Op = 2'b01;
    @(negedge Clock);
    Op = 2'b00; A = 32'd9; B = 32'd9;
    @(negedge Clock);
    Start = 1'b0;
    t = 0;
    while (Done !== 1'b1 && t < W + 10) begin
      @(negedge Clock);
      t++;
    end
    chk("busy_start_done_seen", 64'(Done), 64'd1);
    Start = 1'b1; Op = 2'b11; A = 32'h1234;
    @(negedge Clock);
    Start = 1'b0;
    chk("done_start_ignored_lo", 64'(LO), 64'hFFFF_FFF1);
    chk("done_start_ignored_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("done_start_ignored_busy", 64'(Busy), 64'd0);
    sbq.delete();
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;

    // Clear mid-iteration aborts without Done and zeroes HI/LO.
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; A = 32'd123; B = 32'd456;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    chk("abort_busy_before_clear", 64'(Busy), 64'd1);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    n0 = n_done;
    repeat (W + 5) @(negedge Clock);
    chk("abort_no_done", 64'(n_done), 64'(n0));
    m_hi = '0; m_lo = '0;

    // Normal operation after the abort.
    do_op(2'b00, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, W + 1);

    chk("invariants", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_div_hilo.md
MUL_DIV_HILO -- requirements
Module: mul_div_hilo

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 32, operand, HI and LO width (legal values 8..64, even).
REQ-002 The block SHALL have one clock, Clock, and one reset, Clear, which is synchronous and active-high.
REQ-003 Port list, one per line:
- Clock  input  1  rising-edge clock
- Clear  input  1  synchronous active-high reset
- Start  input  1  operation request, sampled in IDLE only
- Op  input  2  00 MUL signed, 01 DIV signed, 10 MTHI, 11 MTLO
- A  input  WIDTH  multiplicand, dividend, or MTHI/MTLO data
- B  input  WIDTH  multiplier or divisor
- HI  output  WIDTH  HI register, driven continuously for mfhi
- LO  output  WIDTH  LO register, driven continuously for mflo
- Busy  output  1  MUL/DIV in progress
- Done  output  1  one-cycle completion pulse
- DivZero  output  1  one-cycle pulse, coincident with Done, on divide-by-zero

Function
REQ-004 The FSM SHALL have states IDLE, ITER, FIX and DONE.
- IDLE to ITER on Start with Op MUL or DIV.
- ITER to FIX after WIDTH iterations.
- FIX to DONE.
- DONE to IDLE.
REQ-005 MTHI and MTLO in IDLE SHALL load A into HI or LO at that edge, with no Busy, no Done and no state change.
REQ-006 Busy SHALL be 1 in ITER and FIX, and 0 in IDLE and DONE.
REQ-007 Start and all Op values SHALL be ignored while not in IDLE, including in DONE.
REQ-008 A and B SHALL be captured at the Start edge; later changes SHALL have no effect on the result.
REQ-009 MUL SHALL operate on operand magnitudes.
- One shift-add step per ITER cycle.
- FIX applies sign correction.
- {HI,LO} = the full 2*WIDTH signed product.
REQ-010 DIV SHALL be restoring division on magnitudes, one quotient bit per ITER cycle.
- LO = quotient, truncated toward zero.
- HI = remainder, sign equal to the dividend's sign.
REQ-011 DIV of the most negative value by -1 SHALL give LO = the most negative value and HI = 0 (two's-complement wrap), with no flag.
REQ-012 Latency: for Start sampled at edge k, new HI/LO SHALL be visible after edge k+WIDTH+2, with Done=1 in that same cycle only.
REQ-013 HI and LO SHALL hold their previous values throughout ITER and FIX; both SHALL update together at the FIX-to-DONE edge.
REQ-014 DIV with B=0 SHALL go directly IDLE to DONE.
- HI and LO stay unchanged.
- Done=1 and DivZero=1 for that one cycle after edge k+1.
REQ-015 Busy and Done SHALL never be 1 in the same cycle.
REQ-016 DivZero SHALL be 0 whenever Done is 0.

Reset
REQ-017 Clear=1 at a rising edge SHALL force:
- state IDLE
- HI=0 and LO=0
- Busy=0, Done=0, DivZero=0
- iteration counter and internal accumulators to 0
REQ-018 Clear SHALL override Start, Op and any in-flight operation; an aborted operation SHALL NOT update HI/LO and SHALL NOT produce Done.
REQ-019 Outputs SHALL be unknown-free from the first edge with Clear=1.

Configuration
REQ-020 Macro HILO_DIV_EN SHALL control whether the divider is present.
- Defined: divide hardware is built and behaves per REQ-010, REQ-011 and REQ-014.
- Undefined: no divide datapath; Op=01 with Start goes IDLE to DONE, leaves HI/LO unchanged, pulses Done after edge k+1, and keeps DivZero at 0.
- MUL, MTHI and MTLO SHALL be identical in both builds.

Verification (WIDTH=32, HILO_DIV_EN defined unless stated)
REQ-021 MTHI with A=10, then idle -> HI=0x0000000A immediately after the edge; LO unchanged; Busy=0; Done=0.
REQ-022 MUL with A=-3, B=5 -> Busy for 33 cycles; Done pulse in cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-023 DIV 17/5 -> LO=3, HI=2. DIV -17/5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-024 DIV with A=7, B=0 after MTLO 0x55 -> Done=1 and DivZero=1 one cycle after Start; LO=0x55 unchanged.
REQ-025 Second Start with a new Op during Busy is ignored and the first result is correct. Clear asserted at iteration 10 -> next cycle HI=LO=0, Busy=0, Done never pulses.
REQ-026 With HILO_DIV_EN undefined: DIV 17/5 -> Done after 1 cycle; HI/LO unchanged; DivZero=0.
